// File: rtl/ucode_seq_pkg.sv
// Shared definitions for the IU microcode sequencer: branch-op encodings,
// field positions inside u_f18 and the idle ROM address.
package ucode_seq_pkg;

   typedef enum logic [2:0] {
      UC_OP_NEXT = 3'b000,
      UC_OP_JMP  = 3'b001,
      UC_OP_BZ   = 3'b010,
      UC_OP_BNEG = 3'b011,
      UC_OP_BODD = 3'b100,
      UC_OP_CALL = 3'b101,
      UC_OP_RET  = 3'b110,
      UC_OP_DONE = 3'b111
   } uc_op_e;

   typedef enum logic {
      UC_ST_IDLE = 1'b0,
      UC_ST_RUN  = 1'b1
   } uc_state_e;

   localparam logic [8:0] UC_IDLE_ADDR = 9'h000;
   localparam logic [8:0] UC_LAST_ADDR = 9'h1FF;

   // u_f18 layout: [11:9] op, [8:0] target
   localparam int UC_F18_OP_HI  = 11;
   localparam int UC_F18_OP_LO  = 9;
   localparam int UC_F18_TGT_HI = 8;
   localparam int UC_F18_TGT_LO = 0;

   function automatic uc_op_e uc_f18_op(input logic [11:0] f18);
      return uc_op_e'(f18[UC_F18_OP_HI:UC_F18_OP_LO]);
   endfunction

   function automatic logic [8:0] uc_f18_tgt(input logic [11:0] f18);
      return f18[UC_F18_TGT_HI:UC_F18_TGT_LO];
   endfunction

endpackage

// File: rtl/ucode_seq_rstk.sv
// Return-address LIFO for ucode CALL/RET. Top of stack is visible
// combinationally so RET can redirect the ROM address in the same cycle.
module ucode_rstk #(
   parameter int DEPTH = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_clr,
   input  logic [8:0] i_din,
   output logic [8:0] o_top,
   output logic       o_full,
   output logic       o_empty
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [8:0]    r_stk [DEPTH];
   logic [CW-1:0] r_cnt;

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);

   // Top entry sits at index r_cnt-1; selected by compare to stay in range.
   always_comb begin
      o_top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_cnt == CW'(i + 1)) o_top = r_stk[i];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_push && !o_full) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_cnt == CW'(i)) r_stk[i] <= i_din;
         end
         r_cnt <= r_cnt + CW'(1);
      end else if (i_pop && !o_empty) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/ucode_seq.sv
// IU microcode sequencer: turns start/entry plus the current microword's
// branch field into the next ROM address, with stall, kill and error handling.
module ucode_seq
   import ucode_seq_pkg::*;
#(
   parameter int RSTK_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic        ucode_start,
   input  logic [8:0]  ucode_entry,
   input  logic        ie_stall_ucode,
   input  logic        ie_kill_ucode,
   input  logic [11:0] u_f18,
   input  logic [31:0] a_oprd,
   input  logic        a_oprd_0_l,
   input  logic        reg5_31,
   output logic [8:0]  nxt_ucode_cnt,
   output logic        sel_fxx_default,
   output logic        u_abt_cur,
   output logic        ucode_busy,
   output logic        ucode_done,
   output logic        ucode_err
);

   uc_state_e  r_state;
   logic [8:0] r_ucode_cnt;

   uc_state_e  w_state_nxt;
   logic       w_cnt_en;
   uc_op_e     w_op;
   logic [8:0] w_tgt;
   logic [8:0] w_inc;
   logic       w_at_last;
   logic       w_cond;
   logic       w_push;
   logic       w_pop;
   logic       w_clr;
   logic       w_err;
   logic [8:0] w_top;
   logic       w_full;
   logic       w_empty;

   assign w_op      = uc_f18_op(u_f18);
   assign w_tgt     = uc_f18_tgt(u_f18);
   assign w_inc     = r_ucode_cnt + 9'd1;
   assign w_at_last = (r_ucode_cnt == UC_LAST_ADDR);

   always_comb begin
      w_cond = 1'b0;
      case (w_op)
         UC_OP_BZ:   w_cond = (a_oprd == 32'd0);
         UC_OP_BNEG: w_cond = reg5_31;
         UC_OP_BODD: w_cond = !a_oprd_0_l;
         default:    w_cond = 1'b0;
      endcase
   end

   always_comb begin
      nxt_ucode_cnt   = UC_IDLE_ADDR;
      sel_fxx_default = 1'b1;
      u_abt_cur       = 1'b0;
      ucode_busy      = 1'b0;
      ucode_done      = 1'b0;
      w_err           = 1'b0;
      w_push          = 1'b0;
      w_pop           = 1'b0;
      w_clr           = 1'b0;
      w_cnt_en        = 1'b0;
      w_state_nxt     = r_state;

      if (r_state == UC_ST_IDLE) begin
         if (ucode_start) begin
            nxt_ucode_cnt = ucode_entry;
            w_cnt_en      = 1'b1;
            w_state_nxt   = UC_ST_RUN;
         end
      end else begin
         ucode_busy      = 1'b1;
         sel_fxx_default = 1'b0;
         if (ie_kill_ucode) begin
            u_abt_cur       = 1'b1;
            sel_fxx_default = 1'b1;
            w_clr           = 1'b1;
            w_cnt_en        = 1'b1;
            w_state_nxt     = UC_ST_IDLE;
         end else if (ie_stall_ucode) begin
            nxt_ucode_cnt = r_ucode_cnt;
         end else begin
            w_cnt_en = 1'b1;
            case (w_op)
               UC_OP_NEXT: begin
                  nxt_ucode_cnt = w_inc;
                  w_err         = w_at_last;
               end
               UC_OP_JMP: nxt_ucode_cnt = w_tgt;
               UC_OP_BZ, UC_OP_BNEG, UC_OP_BODD: begin
                  nxt_ucode_cnt = w_cond ? w_tgt : w_inc;
                  w_err         = !w_cond && w_at_last;
               end
               UC_OP_CALL: begin
                  nxt_ucode_cnt = w_tgt;
                  w_err         = w_full;
                  w_push        = !w_full;
               end
               UC_OP_RET: begin
                  nxt_ucode_cnt = w_top;
                  w_err         = w_empty;
                  w_pop         = !w_empty;
               end
               UC_OP_DONE: begin
                  ucode_done  = 1'b1;
                  w_state_nxt = UC_ST_IDLE;
               end
            endcase
            // Any sequencing error ends the routine like DONE, minus the done pulse.
            if (w_err) begin
               nxt_ucode_cnt = UC_IDLE_ADDR;
               w_clr         = 1'b1;
               w_state_nxt   = UC_ST_IDLE;
            end
         end
      end
   end

   assign ucode_err = w_err;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_state     <= UC_ST_IDLE;
         r_ucode_cnt <= UC_IDLE_ADDR;
      end else begin
         r_state <= w_state_nxt;
         if (w_cnt_en) r_ucode_cnt <= nxt_ucode_cnt;
      end
   end

   ucode_rstk #(
      .DEPTH (RSTK_DEPTH)
   ) u_rstk (
      .i_clk   (clk),
      .i_rst_n (reset_l),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clr   (w_clr),
      .i_din   (w_inc),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule

// File: tb/tb_ucode_seq.sv
// Directed bench for ucode_seq: a per-cycle vector table plus a hand-written
// asynchronous-reset sequence.
module tb_ucode_seq;

   logic        clk = 1'b0;
   logic        reset_l;
   logic        ucode_start;
   logic [8:0]  ucode_entry;
   logic        ie_stall_ucode;
   logic        ie_kill_ucode;
   logic [11:0] u_f18;
   logic [31:0] a_oprd;
   logic        a_oprd_0_l;
   logic        reg5_31;
   logic [8:0]  nxt_ucode_cnt;
   logic        sel_fxx_default;
   logic        u_abt_cur;
   logic        ucode_busy;
   logic        ucode_done;
   logic        ucode_err;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ucode_seq #(.RSTK_DEPTH(2)) dut (
      .clk             (clk),
      .reset_l         (reset_l),
      .ucode_start     (ucode_start),
      .ucode_entry     (ucode_entry),
      .ie_stall_ucode  (ie_stall_ucode),
      .ie_kill_ucode   (ie_kill_ucode),
      .u_f18           (u_f18),
      .a_oprd          (a_oprd),
      .a_oprd_0_l      (a_oprd_0_l),
      .reg5_31         (reg5_31),
      .nxt_ucode_cnt   (nxt_ucode_cnt),
      .sel_fxx_default (sel_fxx_default),
      .u_abt_cur       (u_abt_cur),
      .ucode_busy      (ucode_busy),
      .ucode_done      (ucode_done),
      .ucode_err       (ucode_err)
   );

   // flag order: {sel_fxx_default, u_abt_cur, ucode_busy, ucode_done, ucode_err}
   localparam logic [4:0] F_IDLE = 5'b10000;
   localparam logic [4:0] F_RUN  = 5'b00100;
   localparam logic [4:0] F_DONE = 5'b00110;
   localparam logic [4:0] F_ERR  = 5'b00101;
   localparam logic [4:0] F_KILL = 5'b11100;

   localparam logic [2:0] OP_NEXT = 3'd0, OP_JMP = 3'd1, OP_BZ = 3'd2, OP_BNEG = 3'd3,
                          OP_BODD = 3'd4, OP_CALL = 3'd5, OP_RET = 3'd6, OP_DONE = 3'd7;

   typedef struct {
      logic        st;
      logic [8:0]  ent;
      logic        stl;
      logic        kl;
      logic [11:0] f;
      logic [31:0] a;
      logic        a0l;
      logic        r5;
      logic [8:0]  nxt;
      logic [4:0]  flg;
   } vec_t;

   vec_t vq[$];

   function automatic logic [11:0] f18(input logic [2:0] op, input logic [8:0] t);
      return {op, t};
   endfunction

   task automatic av(input logic st, input logic [8:0] ent, input logic stl, input logic kl,
                     input logic [11:0] f, input logic [31:0] a, input logic a0l, input logic r5,
                     input logic [8:0] nxt, input logic [4:0] flg);
      vec_t v;
      v.st = st; v.ent = ent; v.stl = stl; v.kl = kl; v.f = f;
      v.a = a; v.a0l = a0l; v.r5 = r5; v.nxt = nxt; v.flg = flg;
      vq.push_back(v);
   endtask

   task automatic strt(input logic [8:0] e);
      av(1'b1, e, 1'b0, 1'b0, 12'h0, 32'd1, 1'b1, 1'b0, e, F_IDLE);
   endtask
   task automatic idl();
      av(1'b0, 9'h0, 1'b0, 1'b0, 12'h0, 32'd1, 1'b1, 1'b0, 9'h000, F_IDLE);
   endtask
   task automatic rn(input logic [11:0] f, input logic [8:0] nxt);
      av(1'b0, 9'h0, 1'b0, 1'b0, f, 32'd1, 1'b1, 1'b0, nxt, F_RUN);
   endtask
   task automatic rc(input logic [11:0] f, input logic [31:0] a, input logic a0l,
                     input logic r5, input logic [8:0] nxt);
      av(1'b0, 9'h0, 1'b0, 1'b0, f, a, a0l, r5, nxt, F_RUN);
   endtask
   task automatic dn();
      av(1'b0, 9'h0, 1'b0, 1'b0, f18(OP_DONE, 9'h0), 32'd1, 1'b1, 1'b0, 9'h000, F_DONE);
   endtask
   task automatic erv(input logic [11:0] f);
      av(1'b0, 9'h0, 1'b0, 1'b0, f, 32'd5, 1'b1, 1'b0, 9'h000, F_ERR);
   endtask
   task automatic stl(input logic [8:0] at);
      av(1'b0, 9'h0, 1'b1, 1'b0, f18(OP_DONE, 9'h0), 32'd1, 1'b1, 1'b0, at, F_RUN);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      ucode_start    = v.st;
      ucode_entry    = v.ent;
      ie_stall_ucode = v.stl;
      ie_kill_ucode  = v.kl;
      u_f18          = v.f;
      a_oprd         = v.a;
      a_oprd_0_l     = v.a0l;
      reg5_31        = v.r5;
   endtask

   function automatic logic [4:0] flags();
      return {sel_fxx_default, u_abt_cur, ucode_busy, ucode_done, ucode_err};
   endfunction

   initial begin
      // basic NEXT, NEXT, DONE from 040
      strt(9'h040); rn(f18(OP_NEXT, 0), 9'h041); rn(f18(OP_NEXT, 0), 9'h042); dn(); idl();
      // conditional branches at 050, taken and untaken (back-to-back starts)
      strt(9'h050); rc(f18(OP_BZ,   9'h080), 32'd0, 1'b1, 1'b0, 9'h080); dn();
      strt(9'h050); rc(f18(OP_BZ,   9'h080), 32'd5, 1'b1, 1'b0, 9'h051); dn();
      strt(9'h050); rc(f18(OP_BNEG, 9'h080), 32'd5, 1'b1, 1'b1, 9'h080); dn();
      strt(9'h050); rc(f18(OP_BNEG, 9'h080), 32'd5, 1'b1, 1'b0, 9'h051); dn();
      strt(9'h050); rc(f18(OP_BODD, 9'h080), 32'd5, 1'b0, 1'b0, 9'h080); dn();
      strt(9'h050); rc(f18(OP_BODD, 9'h080), 32'd4, 1'b1, 1'b0, 9'h051); dn();
      // CALL / RET
      strt(9'h060); rn(f18(OP_CALL, 9'h100), 9'h100); rn(f18(OP_RET, 0), 9'h061); dn();
      // nested CALLs overflow at depth 2
      strt(9'h070); rn(f18(OP_CALL, 9'h100), 9'h100); rn(f18(OP_CALL, 9'h110), 9'h110);
      erv(f18(OP_CALL, 9'h120)); idl();
      // RET on empty stack
      strt(9'h070); erv(f18(OP_RET, 0)); idl();
      // stall 3 cycles at 045, start during RUN ignored
      strt(9'h044); rn(f18(OP_NEXT, 0), 9'h045); stl(9'h045); stl(9'h045); stl(9'h045);
      av(1'b1, 9'h1AA, 1'b0, 1'b0, f18(OP_NEXT, 0), 32'd1, 1'b1, 1'b0, 9'h046, F_RUN); dn();
      // kill while stalled at 045, then new start (with kill asserted in IDLE)
      strt(9'h044); rn(f18(OP_NEXT, 0), 9'h045); stl(9'h045);
      av(1'b0, 9'h0, 1'b1, 1'b1, f18(OP_DONE, 0), 32'd1, 1'b1, 1'b0, 9'h000, F_KILL);
      av(1'b1, 9'h040, 1'b0, 1'b1, 12'h0, 32'd1, 1'b1, 1'b0, 9'h040, F_IDLE);
      rn(f18(OP_NEXT, 0), 9'h041); dn();
      // wrap errors and legal redirects at 1FF
      strt(9'h1FF); erv(f18(OP_NEXT, 0)); idl();
      strt(9'h1FF); erv(f18(OP_BZ, 9'h080));
      strt(9'h1FF); rc(f18(OP_BZ, 9'h080), 32'd0, 1'b1, 1'b0, 9'h080); dn();
      strt(9'h1FF); rn(f18(OP_JMP, 9'h010), 9'h010); dn(); idl();

      reset_l = 1'b0;
      drive(vq[0]);
      ucode_start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_nxt", 32'(nxt_ucode_cnt), 32'h000);
      chk("reset_flags", 32'(flags()), 32'(F_IDLE));
      reset_l = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk); #1;
         drive(vq[i]);
         @(negedge clk);
         chk($sformatf("vec%0d_nxt", i), 32'(nxt_ucode_cnt), 32'(vq[i].nxt));
         chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vq[i].flg));
      end

      // async reset while executing NEXT at 1FF: no error, reset values at once
      @(posedge clk); #1;
      drive(vq[0]);
      ucode_start = 1'b1; ucode_entry = 9'h1FF;
      @(posedge clk); #1;
      ucode_start = 1'b0; u_f18 = f18(OP_NEXT, 0);
      #1 chk("prereset_err", 32'(ucode_err), 32'd1);
      #1 reset_l = 1'b0;
      #1;
      chk("areset_nxt", 32'(nxt_ucode_cnt), 32'h000);
      chk("areset_flags", 32'(flags()), 32'(F_IDLE));
      @(negedge clk);
      reset_l = 1'b1;
      @(posedge clk); #1;
      u_f18 = 12'h0;
      @(negedge clk);
      chk("post_reset_flags", 32'(flags()), 32'(F_IDLE));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ucode_seq.md
# ucode_seq

Microcode sequencer for the IU microcode engine. It accepts a start request and entry address from the IU decode stage and produces `nxt_ucode_cnt` for the ucode ROM each cycle. It evaluates the branch field `u_f18` of the microword currently held in the field register, together with datapath condition inputs, and honours IE stall and kill. It drives `sel_fxx_default` and `u_abt_cur` back into the ucode datapath.

## Interface
Parameters:
- `RSTK_DEPTH`, default 2: return-stack entries (1..4).

Ports:
- `clk`  in  1  core clock.
- `reset_l`  in  1  reset; one clock domain; reset is asynchronous, active-low.
- `ucode_start`  in  1  IU request to begin a microroutine; sampled only in IDLE.
- `ucode_entry`  in  9  entry ROM address, valid with `ucode_start`.
- `ie_stall_ucode`  in  1  IE holds off ucode execution.
- `ie_kill_ucode`  in  1  IU kills the current ucode operation.
- `u_f18`  in  12  branch field of the current microword: [11:9] op, [8:0] target.
- `a_oprd`  in  32  datapath A operand, used for the zero test.
- `a_oprd_0_l`  in  1  a_oprd[0], active low.
- `reg5_31`  in  1  temp reg5 sign bit.
- `nxt_ucode_cnt`  out  9  ROM address for the next microword.
- `sel_fxx_default`  out  1  squashes all ucode field controls.
- `u_abt_cur`  out  1  aborts the current ucode read/write.
- `ucode_busy`  out  1  a microroutine is in progress.
- `ucode_done`  out  1  one-cycle completion pulse.
- `ucode_err`  out  1  one-cycle sequencing-error pulse.

## Operation
- State: IDLE or RUN. Registers: `ucode_cnt` (9b, address of the microword in the field register), the return stack, and `rstk_cnt`.
- IDLE:
  - `nxt_ucode_cnt`=9'h000 (NOP word); `sel_fxx_default`=1.
  - `ucode_start`=1 → `nxt_ucode_cnt`=`ucode_entry`, `ucode_cnt`<=entry, state<=RUN.
- RUN: `sel_fxx_default`=0 and `ucode_busy`=1. `nxt_ucode_cnt` is decoded from `u_f18[11:9]`:
  - 000 NEXT: `ucode_cnt`+1.
  - 001 JMP: target.
  - 010 BZ: target if `a_oprd`==0, else +1.
  - 011 BNEG: target if `reg5_31`, else +1.
  - 100 BODD: target if !`a_oprd_0_l`, else +1.
  - 101 CALL: push `ucode_cnt`+1, go to target.
  - 110 RET: pop; go to the popped address.
  - 111 DONE: 9'h000, `ucode_done`=1, state<=IDLE.
- `ucode_cnt`<=`nxt_ucode_cnt` every non-stalled RUN cycle.
- Stall in RUN: `nxt_ucode_cnt`=`ucode_cnt`; all registers hold. No done, err, push or pop takes effect.
- Kill, priority over stall, start and all ops, in RUN:
  - `u_abt_cur`=1 and `sel_fxx_default`=1 in the same cycle; `nxt_ucode_cnt`=9'h000.
  - state<=IDLE, return stack cleared.
  - No `ucode_done` is produced.
- Kill in IDLE: no effect. `ucode_start` in RUN: ignored.
- Errors: each pulses `ucode_err` for one cycle, behaves like DONE without `ucode_done`, and clears the stack.
  - CALL with the stack full.
  - RET with the stack empty.
  - NEXT or untaken branch at `ucode_cnt`=9'h1FF (wrap).
- Reset values: state IDLE, `ucode_cnt`=0, stack empty.
  - Outputs: `nxt_ucode_cnt`=0, `sel_fxx_default`=1, `u_abt_cur`=0, busy/done/err=0.
- Reset asserted mid-routine: immediate return to the reset values.

## Timing
- All outputs are combinational from registered state plus the current-cycle `u_f18`, conditions, stall and kill. No input-to-output path runs through the start-to-RUN transition.
- ROM field latency is 1 cycle:
  - address presented in cycle N → its fields appear at `u_f18` in N+1.
  - start in cycle N → entry word executes in N+1 → first sequenced address is presented in N+1.
- A routine of k words, unstalled, holds busy for k cycles. `ucode_done` coincides with the DONE word.
- Back-to-back: `ucode_start` is accepted in the cycle after DONE.

## Structure
- Shared defines file holds:
  - op encodings `UC_OP_NEXT`..`UC_OP_DONE`
  - `UC_IDLE_ADDR`=9'h000
  - field positions `UC_F18_OP`, `UC_F18_TGT`
- Sub-module `ucode_rstk`: LIFO, `RSTK_DEPTH`×9b, with push/pop/clear, full/empty and async reset. Push and pop are never asserted together.

## Test plan
- Start with entry 9'h040, words NEXT, NEXT, DONE → addresses 040, 041, 042, then 000; busy for 3 cycles; done pulse on cycle 3.
- BZ to 9'h080 at 9'h050 with `a_oprd`=0 → next is 080. Same with `a_oprd`=5 → next is 051. Repeat for BNEG and BODD.
- CALL 9'h100 at 9'h060; at 100, RET → next is 061. Three nested CALLs with depth 2 → `ucode_err` on the third, IDLE, addr 000.
- Stall for 3 cycles mid-routine at 9'h045 → `nxt_ucode_cnt` holds 045 and the sequence resumes unchanged.
- Kill while stalled at 9'h045 → `u_abt_cur`=1 and `sel_fxx_default`=1 that cycle, no done, IDLE next cycle; a new start is accepted.
- Async reset mid-routine at 9'h1FF NEXT → outputs return to reset values with no `ucode_err`. Without reset, the same case raises `ucode_err`.
